fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter width_p, default 32, meaning address/instruction width in bits.
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port pc_i  input  width_p  current PC from program counter.
REQ-005 SHALL have port take_branch_i  input  1  redirect/flush, same signal that loads the branch target into the PC.
REQ-006 SHALL have port pc_stall_o  output  1  high = PC must hold its value this cycle.
REQ-007 SHALL have ports imem_req_o  output  1  request valid; imem_addr_o  output  width_p  request address; imem_ready_i  input  1  memory accepts request.
REQ-008 SHALL have ports imem_rvalid_i  input  1  response valid; imem_rdata_i  input  width_p  response instruction.
REQ-009 SHALL have ports instr_valid_o  output  1; instr_o  output  width_p; instr_pc_o  output  width_p; instr_ready_i  input  1  decode handshake.
REQ-010 SHALL have port instr_misaligned_o  output  1  fetch fault flag, qualified by instr_valid_o.

Function
REQ-011 SHALL implement FSM states IDLE, REQ, WAIT, HOLD; at most one memory request outstanding.
REQ-012 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-013 In REQ, imem_req_o SHALL be 1 and imem_addr_o SHALL equal pc_i, except imem_req_o = 0 in any cycle take_branch_i = 1.
REQ-014 REQ -> WAIT when imem_req_o & imem_ready_i; the accepted address SHALL be captured as the instruction's PC.
REQ-015 pc_stall_o SHALL be 0 when take_branch_i = 1 or when imem_req_o & imem_ready_i, and 1 otherwise.
REQ-016 WAIT -> HOLD on imem_rvalid_i: imem_rdata_i registered into instr_o, captured PC into instr_pc_o; instr_valid_o = 1 from the next cycle (response-to-valid latency 1 cycle).
REQ-017 In HOLD, instr_valid_o, instr_o, instr_pc_o SHALL remain stable until instr_ready_i = 1; HOLD -> REQ on instr_valid_o & instr_ready_i.
REQ-018 take_branch_i in WAIT SHALL set a discard flag; the pending response SHALL be dropped (no HOLD), then FSM -> REQ; discard flag cleared on that response.
REQ-019 take_branch_i in HOLD SHALL deassert instr_valid_o next cycle and go to REQ, regardless of instr_ready_i.
REQ-020 take_branch_i in REQ SHALL keep FSM in REQ; the next request uses the updated pc_i.
REQ-021 imem_rvalid_i outside WAIT (without discard pending) SHALL be ignored.

Reset
REQ-022 While rst_ni = 0 at a rising edge: state IDLE, discard flag 0, instr_valid_o 0, instr_o 0, instr_pc_o 0, instr_misaligned_o 0.
REQ-023 During reset and in IDLE, imem_req_o SHALL be 0 and pc_stall_o SHALL be 1.
REQ-024 Reset mid-transaction SHALL abandon any outstanding request; a late response after reset release SHALL be ignored until a new request is accepted.

Configuration
REQ-025 With macro FETCH_MISALIGN_CHECK_EN defined: in REQ, pc_i[1:0] != 0 SHALL suppress imem_req_o, go directly to HOLD with instr_misaligned_o = 1, instr_o = 0, instr_pc_o = pc_i, pc_stall_o = 1.
REQ-026 Without FETCH_MISALIGN_CHECK_EN: instr_misaligned_o SHALL be tied 0 and pc_i is issued unchecked.

Verification
REQ-027 Reset release, imem_ready_i = 1, 1-cycle memory returning 0x00000013 for pc 0 -> instr_valid_o with instr_o = 0x00000013, instr_pc_o = 0; next request addr 4.
REQ-028 instr_ready_i held 0 for 5 cycles in HOLD -> instr_o/instr_pc_o stable, pc_stall_o = 1, no imem_req_o.
REQ-029 take_branch_i pulse in WAIT, target 0x100 -> stale response dropped, next imem_addr_o = 0x100, delivered instr_pc_o = 0x100.
REQ-030 imem_ready_i = 0 for 3 cycles in REQ -> imem_req_o held with constant imem_addr_o, pc_stall_o = 1 throughout.
REQ-031 rst_ni low for 1 cycle while in WAIT, late imem_rvalid_i after release -> no instr_valid_o from it; first fetch at pc 0.
REQ-032 With FETCH_MISALIGN_CHECK_EN, pc_i = 0x102 -> no imem_req_o, instr_valid_o = 1, instr_misaligned_o = 1, instr_pc_o = 0x102.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage.
//
// Issues one instruction-memory request at a time for the PC supplied by the
// program counter, holds the PC while a fetch is in flight, and presents the
// returned instruction to decode with a valid/ready handshake. A branch
// (take_branch_i) flushes whatever is in flight or being held.
//
// Optional feature: define FETCH_MISALIGN_CHECK_EN to trap PCs whose low two
// bits are non-zero. Instead of issuing a request, the stage presents a
// faulting slot to decode with instr_misaligned_o set. Without the macro the
// flag is tied low and every PC is issued unchecked.
module fetch_stage #(
    parameter int unsigned width_p = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [width_p-1:0] pc_i,
    input  logic               take_branch_i,
    output logic               pc_stall_o,
    output logic               imem_req_o,
    output logic [width_p-1:0] imem_addr_o,
    input  logic               imem_ready_i,
    input  logic               imem_rvalid_i,
    input  logic [width_p-1:0] imem_rdata_i,
    output logic               instr_valid_o,
    output logic [width_p-1:0] instr_o,
    output logic [width_p-1:0] instr_pc_o,
    input  logic               instr_ready_i,
    output logic               instr_misaligned_o
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StHold
    } state_e;

    state_e             state_q, state_d;
    logic               discard_q, discard_d;
    logic [width_p-1:0] req_pc_q, req_pc_d;
    logic               valid_q, valid_d;
    logic [width_p-1:0] instr_q, instr_d;
    logic [width_p-1:0] instr_pc_q, instr_pc_d;

    logic               misaligned_pc;
    logic               in_req;
    logic               accept;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic               misaligned_q, misaligned_d;

    assign misaligned_pc      = (pc_i[1:0] != 2'b00);
    assign instr_misaligned_o = misaligned_q;
`else
    assign misaligned_pc      = 1'b0;
    assign instr_misaligned_o = 1'b0;
`endif

    // Request side: combinational so a branch can suppress the request in the same cycle.
    always_comb begin
        in_req      = rst_ni && (state_q == StReq);
        imem_req_o  = in_req && !take_branch_i && !misaligned_pc;
        imem_addr_o = pc_i;
        accept      = imem_req_o && imem_ready_i;
        // The PC may only move when the current address was taken or a branch reloads it.
        if (!rst_ni || (state_q == StIdle)) begin
            pc_stall_o = 1'b1;
        end else begin
            pc_stall_o = !(take_branch_i || accept);
        end
    end

    // Next-state decode for the fetch FSM and its registered outputs.
    always_comb begin
        state_d    = state_q;
        discard_d  = discard_q;
        req_pc_d   = req_pc_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
        misaligned_d = misaligned_q;
`endif

        case (state_q)
            StIdle: begin
                state_d = StReq;
            end

            StReq: begin
                // A branch keeps us here; the reloaded PC is issued next cycle.
                if (!take_branch_i) begin
                    if (misaligned_pc) begin
                        state_d    = StHold;
                        valid_d    = 1'b1;
                        instr_d    = '0;
                        instr_pc_d = pc_i;
`ifdef FETCH_MISALIGN_CHECK_EN
                        misaligned_d = 1'b1;
`endif
                    end else if (accept) begin
                        state_d  = StWait;
                        req_pc_d = pc_i;
                    end
                end
            end

            StWait: begin
                if (imem_rvalid_i) begin
                    if (discard_q || take_branch_i) begin
                        // Response belongs to a flushed path: drop it and refetch.
                        state_d   = StReq;
                        discard_d = 1'b0;
                    end else begin
                        state_d    = StHold;
                        valid_d    = 1'b1;
                        instr_d    = imem_rdata_i;
                        instr_pc_d = req_pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
                        misaligned_d = 1'b0;
`endif
                    end
                end else if (take_branch_i) begin
                    // Cannot cancel the bus transaction, so remember to drop its response.
                    discard_d = 1'b1;
                end
            end

            StHold: begin
                if (take_branch_i || instr_ready_i) begin
                    state_d = StReq;
                    valid_d = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
                    misaligned_d = 1'b0;
`endif
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            discard_q  <= 1'b0;
            req_pc_q   <= '0;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            discard_q  <= discard_d;
            req_pc_q   <= req_pc_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            misaligned_q <= misaligned_d;
`endif
        end
    end

    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by randomized traffic.
// The bench owns the program counter and a variable-latency instruction memory,
// and predicts the program-order stream of fetch addresses and delivered
// instructions (sequential +4, restarting at each branch target).
module tb_fetch_stage;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] pc;
    logic         take_branch;
    logic         pc_stall;
    logic         imem_req;
    logic [W-1:0] imem_addr;
    logic         imem_ready;
    logic         imem_rvalid;
    logic [W-1:0] imem_rdata;
    logic         instr_valid;
    logic [W-1:0] instr;
    logic [W-1:0] instr_pc;
    logic         instr_ready;
    logic         instr_mis;

    always #5 clk = ~clk;

    fetch_stage #(.width_p(W)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .pc_i              (pc),
        .take_branch_i     (take_branch),
        .pc_stall_o        (pc_stall),
        .imem_req_o        (imem_req),
        .imem_addr_o       (imem_addr),
        .imem_ready_i      (imem_ready),
        .imem_rvalid_i     (imem_rvalid),
        .imem_rdata_i      (imem_rdata),
        .instr_valid_o     (instr_valid),
        .instr_o           (instr),
        .instr_pc_o        (instr_pc),
        .instr_ready_i     (instr_ready),
        .instr_misaligned_o(instr_mis)
    );

    int checks = 0;
    int errors = 0;

    // Outputs sampled at the negedge of the most recent cycle.
    logic         s_req, s_stall, s_valid, s_mis;
    logic [W-1:0] s_addr, s_instr, s_ipc;

    // Program-order model and memory model state.
    logic [W-1:0] br_target;
    logic [W-1:0] fetch_exp;
    logic [W-1:0] deliv_exp;
    bit           model_on;
    bit           rand_mode;
    int           ndeliv = 0;
    bit           mem_pend = 0;
    int           mem_cnt = 0;
    logic [W-1:0] mem_addr;
    int           lat;

    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        return a * 3 + 32'h13;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample and check at negedge, then advance PC, memory and stimulus.
    task automatic cycle();
        logic acc, hs;
        @(negedge clk);
        s_req   = imem_req;
        s_stall = pc_stall;
        s_valid = instr_valid;
        s_mis   = instr_mis;
        s_addr  = imem_addr;
        s_instr = instr;
        s_ipc   = instr_pc;
        acc = imem_req && imem_ready;
        hs  = instr_valid && instr_ready && rst_n && !take_branch;
        if (model_on && rst_n) begin
            if (acc) begin
                chk("fetch_addr", imem_addr, fetch_exp);
                chk("one_outstanding", {31'b0, mem_pend}, 0);
                fetch_exp = fetch_exp + 4;
            end
            if (hs) begin
                chk("deliv_pc", instr_pc, deliv_exp);
                chk("deliv_instr", instr, mem_word(deliv_exp));
                chk("deliv_mis", {31'b0, instr_mis}, 0);
                deliv_exp = deliv_exp + 4;
                ndeliv++;
            end
            if (take_branch) begin
                fetch_exp = br_target;
                deliv_exp = br_target;
            end
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            pc        = '0;
            fetch_exp = '0;
            deliv_exp = '0;
        end else if (take_branch) begin
            pc = br_target;
        end else if (!s_stall) begin
            pc = pc + 4;
        end
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (acc) begin
            mem_pend = 1;
            mem_cnt  = lat;
            mem_addr = s_addr;
        end
        if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt <= 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_addr);
                mem_pend    = 0;
            end
        end
        if (rand_mode) begin
            take_branch = ($urandom_range(0, 99) < 5);
            br_target   = $urandom & 32'h0000_fffc;
            imem_ready  = ($urandom_range(0, 99) < 70);
            instr_ready = $urandom_range(0, 1) != 0;
            lat         = $urandom_range(1, 3);
        end else begin
            take_branch = 1'b0;
        end
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!s_valid && n < budget);
        chk("valid_timeout", {31'b0, s_valid}, 1);
    endtask

    initial begin
        int  n;
        bit  saw;
        rst_n       = 1'b0;
        pc          = '0;
        take_branch = 1'b0;
        br_target   = '0;
        imem_ready  = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        lat         = 1;
        model_on    = 1;
        rand_mode   = 0;
        fetch_exp   = '0;
        deliv_exp   = '0;

        // Reset state
        cycle();
        cycle();
        chk("rst_req", {31'b0, s_req}, 0);
        chk("rst_stall", {31'b0, s_stall}, 1);
        chk("rst_valid", {31'b0, s_valid}, 0);
        chk("rst_instr", s_instr, 0);
        chk("rst_ipc", s_ipc, 0);
        chk("rst_mis", {31'b0, s_mis}, 0);

        // First fetch at pc 0 with a 1-cycle memory
        rst_n = 1'b1;
        cycle();
        chk("idle_req", {31'b0, s_req}, 0);
        chk("idle_stall", {31'b0, s_stall}, 1);
        cycle();
        chk("req0_req", {31'b0, s_req}, 1);
        chk("req0_addr", s_addr, 0);
        chk("req0_stall", {31'b0, s_stall}, 0);
        wait_valid(10);
        chk("first_instr", s_instr, 32'h13);
        chk("first_pc", s_ipc, 0);
        chk("first_mis", {31'b0, s_mis}, 0);

        // Decode back-pressure: held slot stays stable, PC stalled, no request
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("hold_valid", {31'b0, s_valid}, 1);
            chk("hold_instr", s_instr, 32'h13);
            chk("hold_pc", s_ipc, 0);
            chk("hold_stall", {31'b0, s_stall}, 1);
            chk("hold_req", {31'b0, s_req}, 0);
        end
        lat         = 3;
        instr_ready = 1'b1;
        cycle();
        instr_ready = 1'b0;
        cycle();
        chk("next_req", {31'b0, s_req}, 1);
        chk("next_addr", s_addr, 32'h4);

        // Branch while waiting: stale response dropped, refetch from target
        take_branch = 1'b1;
        br_target   = 32'h100;
        cycle();
        chk("br_stall", {31'b0, s_stall}, 0);
        saw = 0;
        n   = 0;
        do begin
            cycle();
            n++;
            if (s_valid) saw = 1;
        end while (!s_req && n < 10);
        chk("br_req_seen", {31'b0, s_req}, 1);
        chk("br_no_stale", {31'b0, saw}, 0);
        chk("br_addr", s_addr, 32'h100);
        wait_valid(10);
        chk("br_pc", s_ipc, 32'h100);
        chk("br_instr", s_instr, mem_word(32'h100));

        // Memory not ready: request and address held, PC stalled
        instr_ready = 1'b1;
        imem_ready  = 1'b0;
        cycle();
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("nr_req", {31'b0, s_req}, 1);
            chk("nr_addr", s_addr, 32'h104);
            chk("nr_stall", {31'b0, s_stall}, 1);
        end
        imem_ready = 1'b1;
        lat        = 3;
        cycle();

        // Reset while waiting; the late response must not surface
        rst_n = 1'b0;
        cycle();
        chk("rst2_req", {31'b0, s_req}, 0);
        chk("rst2_stall", {31'b0, s_stall}, 1);
        rst_n      = 1'b1;
        imem_ready = 1'b0;
        lat        = 1;
        cycle();
        chk("rel_valid", {31'b0, s_valid}, 0);
        cycle();
        chk("late_req", {31'b0, s_req}, 1);
        chk("late_addr", s_addr, 0);
        imem_ready = 1'b1;
        cycle();
        chk("late_valid", {31'b0, s_valid}, 0);
        wait_valid(10);
        chk("rst_first_pc", s_ipc, 0);
        chk("rst_first_instr", s_instr, 32'h13);
        instr_ready = 1'b1;
        cycle();
        instr_ready = 1'b0;

`ifdef FETCH_MISALIGN_CHECK_EN
        // Misaligned PC: no request, faulting slot presented to decode
        model_on    = 0;
        take_branch = 1'b1;
        br_target   = 32'h102;
        cycle();
        saw = 0;
        n   = 0;
        do begin
            cycle();
            n++;
            if (s_req) saw = 1;
        end while (!s_valid && n < 10);
        chk("mis_valid", {31'b0, s_valid}, 1);
        chk("mis_flag", {31'b0, s_mis}, 1);
        chk("mis_pc", s_ipc, 32'h102);
        chk("mis_instr", s_instr, 0);
        chk("mis_noreq", {31'b0, saw}, 0);
        chk("mis_stall", {31'b0, s_stall}, 1);
        take_branch = 1'b1;
        br_target   = '0;
        cycle();
        fetch_exp = '0;
        deliv_exp = '0;
        model_on  = 1;
`endif

        // Randomized traffic against the program-order model
        rand_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            cycle();
        end
        chk("progress", {31'b0, ndeliv > 100}, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
